// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar-lander sequencer.
package ll_pkg;

   typedef enum logic [1:0] {RUN, PAUSE, LANDED, CRASHED} ll_state_t;

   typedef enum logic [1:0] {DISP_ALT, DISP_VEL, DISP_FUEL, DISP_THRUST} ll_disp_t;

   localparam logic [4:0] KEY_PAUSE = 5'd10;
   localparam logic [4:0] KEY_W     = 5'd16;
   localparam logic [4:0] KEY_X     = 5'd17;
   localparam logic [4:0] KEY_Y     = 5'd18;
   localparam logic [4:0] KEY_Z     = 5'd19;

   localparam logic [15:0] CRASH_VEL_DEF   = 16'h9970;
   localparam logic [15:0] THRUST_INIT_DEF = 16'h0005;

   // Negative BCD ten's-complement values have a leading digit of 5..9, and
   // within that range unsigned order matches signed order.
   function automatic logic is_crash(input logic [15:0] vel, input logic [15:0] lim);
      return (vel[15:12] >= 4'd5) && (vel < lim);
   endfunction

endpackage

// File: rtl/ll_if.sv
// Signals between the sequencer and the key synchronizer, ALU/state memory and display.
interface ll_if;
   import ll_pkg::*;

   // There is no valid/ready handshake. keyclk is a level strobe, and only its
   // rising edge counts as an event. wen is a one-cycle commit pulse that the
   // memory must take unconditionally. All other signals are plain levels.
   logic        keyclk;
   logic [4:0]  keycode;
   logic [15:0] alt;
   logic [15:0] vel;
   logic [15:0] alt_n;
   logic        wen;
   logic [15:0] thrust;
   ll_disp_t    disp_sel;
   logic        paused;
   logic        land;
   logic        crash;

   modport master (
      output keyclk, keycode, alt, vel, alt_n,
      input  wen, thrust, disp_sel, paused, land, crash
   );

   modport slave (
      input  keyclk, keycode, alt, vel, alt_n,
      output wen, thrust, disp_sel, paused, land, crash
   );

endinterface

// File: rtl/ll_tick_gen.sv
// Simulation-step timebase: the counter advances only while enabled and holds otherwise.
module ll_tick_gen #(
   parameter int TICK_DIV = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/ll_sequencer.sv
// Lunar-lander control unit: step timebase, commit pulse, keypad actions and
// touchdown classification.
module ll_sequencer
   import ll_pkg::*;
#(
   parameter int          TICK_DIV    = 25,
   parameter logic [15:0] THRUST_INIT = THRUST_INIT_DEF,
   parameter logic [15:0] CRASH_VEL   = CRASH_VEL_DEF
) (
   input  logic      clk,
   input  logic      rst,
   ll_if.slave       bus,
   output ll_state_t state_dbg
);

   ll_state_t   state, state_n;
   logic        key_q;
   logic        key_evt;
   logic        tick;
   logic        wen_r;
   logic [15:0] thrust_r, thrust_n;
   ll_disp_t    disp_r, disp_n;
   logic        land_r, land_n;
   logic        crash_r, crash_n;
   logic        pend_v, pend_v_n;
   logic [3:0]  pend_d, pend_d_n;
   logic        is_digit;
   logic        live;

   ll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state == RUN),
      .tick (tick)
   );

   assign key_evt  = bus.keyclk & ~key_q;
   assign is_digit = (bus.keycode < 5'd10);
   assign live     = (state == RUN) || (state == PAUSE);

   always_comb begin
      state_n  = state;
      thrust_n = thrust_r;
      disp_n   = disp_r;
      land_n   = land_r;
      crash_n  = crash_r;
      pend_v_n = 1'b0;
      pend_d_n = pend_d;

      case (state)
         RUN: begin
            // Touchdown is checked first so a simultaneous pause key is dropped.
            if (tick && (bus.alt_n == 16'h0000)) begin
               if (is_crash(bus.vel, CRASH_VEL)) begin
                  state_n = CRASHED;
                  crash_n = 1'b1;
               end else begin
                  state_n = LANDED;
                  land_n  = 1'b1;
               end
            end else if (key_evt && (bus.keycode == KEY_PAUSE)) begin
               state_n = PAUSE;
            end
         end
         PAUSE: begin
            if (key_evt && (bus.keycode == KEY_PAUSE)) state_n = RUN;
         end
         default: state_n = state;
      endcase

      // A digit arriving in a tick cycle is parked for one cycle so the commit
      // pulse still sees the thrust that was active during the step.
      if (key_evt && is_digit && live) begin
         if (tick) begin
            pend_v_n = 1'b1;
            pend_d_n = bus.keycode[3:0];
         end else begin
            thrust_n = {12'h000, bus.keycode[3:0]};
         end
      end else if (pend_v) begin
         thrust_n = {12'h000, pend_d};
      end

      if (key_evt) begin
         case (bus.keycode)
            KEY_Z:   disp_n = DISP_ALT;
            KEY_Y:   disp_n = DISP_VEL;
            KEY_X:   disp_n = DISP_FUEL;
            KEY_W:   disp_n = DISP_THRUST;
            default: disp_n = disp_r;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         key_q    <= 1'b0;
         wen_r    <= 1'b0;
         thrust_r <= THRUST_INIT;
         disp_r   <= DISP_ALT;
         land_r   <= 1'b0;
         crash_r  <= 1'b0;
         pend_v   <= 1'b0;
         pend_d   <= 4'h0;
      end else begin
         state    <= state_n;
         key_q    <= bus.keyclk;
         wen_r    <= tick;
         thrust_r <= thrust_n;
         disp_r   <= disp_n;
         land_r   <= land_n;
         crash_r  <= crash_n;
         pend_v   <= pend_v_n;
         pend_d   <= pend_d_n;
      end
   end

   assign bus.wen      = wen_r;
   assign bus.thrust   = thrust_r;
   assign bus.disp_sel = disp_r;
   assign bus.paused   = (state == PAUSE);
   assign bus.land     = land_r;
   assign bus.crash    = crash_r;
   assign state_dbg    = state;

endmodule

// File: tb/tb_ll_sequencer.sv
// Scoreboard bench for ll_sequencer with TICK_DIV=4 and directed key/touchdown scenarios.
module tb_ll_sequencer;
   import ll_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   ll_state_t   state_dbg;
   int unsigned cyc;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;

   ll_if bus();

   ll_sequencer #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // scoreboard: entries are {cycle[15:0], thrust}
   function automatic void expect_wen(input int c, input logic [15:0] t);
      logic [31:0] e;
      e = {c[15:0], t};
      exp_q.push_back(e);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.wen === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL wen_unexpected: wen=1 at cyc %0d thrust %0h, expected none", cyc, bus.thrust);
            end else begin
               mon_e = exp_q.pop_front();
               if ({cyc[15:0], bus.thrust} !== mon_e) begin
                  bad++;
                  $display("FAIL wen_commit: got cyc %0d thrust %0h expected cyc %0d thrust %0h",
                           cyc, bus.thrust, mon_e[31:16], mon_e[15:0]);
               end
            end
         end
      end
   end

   // driver tasks
   task automatic wait_cyc(input int unsigned n);
      int g;
      g = 0;
      while (cyc != n && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (cyc != n) begin
         total++;
         bad++;
         $display("FAIL wait_timeout: cyc %0d expected %0d", cyc, n);
      end
   endtask

   task automatic do_reset(input logic [15:0] alt_n_v, input logic [15:0] vel_v);
      @(negedge clk);
      #2 rst = 1'b1;
      bus.keyclk  = 1'b0;
      bus.keycode = 5'd0;
      bus.alt     = 16'h0100;
      bus.alt_n   = alt_n_v;
      bus.vel     = vel_v;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press(input logic [4:0] code);
      bus.keycode = code;
      bus.keyclk  = 1'b1;
      @(negedge clk);
      bus.keyclk  = 1'b0;
   endtask

   task automatic drain(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      bus.keyclk  = 1'b0;
      bus.keycode = 5'd0;
      bus.alt     = 16'h0100;
      bus.vel     = 16'h0000;
      bus.alt_n   = 16'h4495;
      #1 rst = 1'b1;
      #1;
      check("rst_wen",    bus.wen, 0);
      check("rst_thrust", bus.thrust, 16'h0005);
      check("rst_disp",   bus.disp_sel, 0);
      check("rst_flags",  {bus.paused, bus.land, bus.crash}, 0);
      check("rst_state",  state_dbg, RUN);

      // 1: free-running commit pulses
      do_reset(16'h4495, 16'h0000);
      expect_wen(4, 16'h0005);
      expect_wen(8, 16'h0005);
      expect_wen(12, 16'h0005);
      wait_cyc(13);
      check("t1_thrust", bus.thrust, 16'h0005);
      check("t1_disp",   bus.disp_sel, 0);
      drain("t1_drain");

      // 2: held key gives one event; keycode change while held is ignored
      do_reset(16'h4495, 16'h0000);
      expect_wen(4, 16'h0007);
      expect_wen(8, 16'h0007);
      expect_wen(12, 16'h0007);
      bus.keycode = 5'd7;
      bus.keyclk  = 1'b1;
      wait_cyc(2);
      bus.keycode = 5'd3;
      wait_cyc(10);
      bus.keyclk  = 1'b0;
      wait_cyc(11);
      press(KEY_Y);
      wait_cyc(13);
      check("t2_thrust", bus.thrust, 16'h0007);
      check("t2_disp",   bus.disp_sel, 1);
      drain("t2_drain");

      // 3: pause holds the counter mid-period
      do_reset(16'h4495, 16'h0000);
      expect_wen(25, 16'h0005);
      expect_wen(29, 16'h0005);
      wait_cyc(1);
      press(KEY_PAUSE);
      check("t3_paused", bus.paused, 1);
      check("t3_state",  state_dbg, PAUSE);
      wait_cyc(22);
      check("t3_still_paused", bus.paused, 1);
      press(KEY_PAUSE);
      check("t3_resumed", bus.paused, 0);
      wait_cyc(30);
      drain("t3_drain");

      // 4: safe touchdown, then terminal
      do_reset(16'h0000, 16'h9985);
      expect_wen(4, 16'h0005);
      wait_cyc(5);
      check("t4_land",  bus.land, 1);
      check("t4_crash", bus.crash, 0);
      wait_cyc(6);
      press(5'd3);
      wait_cyc(8);
      press(KEY_W);
      wait_cyc(10);
      check("t4_disp_w", bus.disp_sel, 3);
      wait_cyc(45);
      check("t4_thrust", bus.thrust, 16'h0005);
      check("t4_state",  state_dbg, LANDED);
      drain("t4_drain");

      // 5a: crash below threshold
      do_reset(16'h0000, 16'h9960);
      expect_wen(4, 16'h0005);
      wait_cyc(5);
      check("t5a_crash", bus.crash, 1);
      check("t5a_land",  bus.land, 0);
      drain("t5a_drain");

      // 5b: threshold is safe; pause key in touchdown cycle is discarded
      do_reset(16'h0000, 16'h9970);
      expect_wen(4, 16'h0005);
      wait_cyc(3);
      press(KEY_PAUSE);
      wait_cyc(5);
      check("t5b_land",   bus.land, 1);
      check("t5b_crash",  bus.crash, 0);
      check("t5b_paused", bus.paused, 0);
      drain("t5b_drain");

      // 6: digit in tick cycle, then async reset while wen is high
      do_reset(16'h4495, 16'h9960);
      expect_wen(4, 16'h0005);
      expect_wen(8, 16'h0009);
      wait_cyc(3);
      press(5'd9);
      wait_cyc(5);
      check("t6_thrust_new", bus.thrust, 16'h0009);
      bus.alt_n = 16'h0000;
      wait_cyc(8);
      #2;
      check("t6_wen_hi",   bus.wen, 1);
      check("t6_crash_hi", bus.crash, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_wen",    bus.wen, 0);
      check("t6_rst_crash",  bus.crash, 0);
      check("t6_rst_land",   bus.land, 0);
      check("t6_rst_thrust", bus.thrust, 16'h0005);
      check("t6_rst_state",  state_dbg, RUN);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
